// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two cores.
// A grant runs through ACCESS, WAIT (mem_latency cycles) and RESP, where the owner gets a one-cycle ack.
module dmem_arbiter #(
  parameter int addr_width  = 12,
  parameter int data_width  = 12,
  parameter int mem_latency = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req1,
  input  logic                  wren1,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata1,
  output logic                  ack1,
  output logic [data_width-1:0] rdata1,
  input  logic                  req2,
  input  logic                  wren2,
  input  logic [addr_width-1:0] addr2,
  input  logic [data_width-1:0] wdata2,
  output logic                  ack2,
  output logic [data_width-1:0] rdata2,
  output logic [addr_width-1:0] mem_address,
  output logic [data_width-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [data_width-1:0] mem_q,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [1:0] LAT_INIT = 2'(mem_latency);

  state_t     state;
  state_t     state_next;
  logic       pend_wren;
  logic       ptr;
  logic [1:0] wait_cnt;
  logic       grant_valid;
  logic       grant_sel;
  logic       wait_last;

  // With both cores requesting, the pointer breaks the tie; 0 selects core1.
  assign grant_valid = req1 | req2;
  assign grant_sel   = (req1 & req2) ? ptr : req2;
  assign wait_last   = (wait_cnt == 2'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = WAIT;
      WAIT:    if (wait_last) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign mem_wren = (state == ACCESS) && pend_wren;
  assign ack1     = (state == RESP) && !owner;
  assign ack2     = (state == RESP) && owner;

  // Request inputs are only looked at in IDLE; everything after that runs from the captured copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address <= '0;
      mem_data    <= '0;
      pend_wren   <= 1'b0;
      owner       <= 1'b0;
      ptr         <= 1'b0;
      wait_cnt    <= '0;
      rdata1      <= '0;
      rdata2      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            mem_address <= grant_sel ? addr2 : addr1;
            mem_data    <= grant_sel ? wdata2 : wdata1;
            pend_wren   <= grant_sel ? wren2 : wren1;
            owner       <= grant_sel;
            ptr         <= ~grant_sel;
          end
        end
        ACCESS: wait_cnt <= LAT_INIT;
        WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_last && !pend_wren) begin
            if (owner) rdata2 <= mem_q;
            else       rdata1 <= mem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the shared single-port data memory (MemoryQ) between two processor cores (core1, core2). Each core issues a level-held read/write request. The arbiter selects one core round-robin, sequences the memory access, waits out the memory read latency, and returns read data with a one-cycle ack. It sits between both cores' AR_to_mem/DR_out/mem_write signals and the MemoryQ address/data/wren/q ports.

Parameters:
addr_width, 12, width of memory address
data_width, 12, width of memory data
mem_latency, 1, clock cycles from address registered at the memory to valid q; legal values 1..3

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req1  input  1  core1 access request, level, held until ack1
wren1  input  1  core1 write (1) / read (0), stable while req1
addr1  input  addr_width  core1 address, stable while req1
wdata1  input  data_width  core1 write data, stable while req1
ack1  output  1  one-cycle pulse: core1 transaction complete
rdata1  output  data_width  core1 read data, valid when ack1, held until next core1 read ack
req2, wren2, addr2, wdata2, ack2, rdata2  same as core1 set, for core2
mem_address  output  addr_width  to MemoryQ address
mem_data  output  data_width  to MemoryQ data
mem_wren  output  1  to MemoryQ wren
mem_q  input  data_width  from MemoryQ q
busy  output  1  high whenever state is not IDLE
owner  output  1  0 = core1, 1 = core2; current/last granted core

Behaviour:
- Reset: state IDLE; ack1=ack2=0, mem_wren=0, mem_address=0, mem_data=0, rdata1=rdata2=0, owner=0, busy=0, priority pointer=core1.
- FSM states are IDLE, ACCESS, WAIT, RESP.
- IDLE: if neither req is high, stay in IDLE.
  - If exactly one req is high, grant that core.
  - If both are high, grant the core named by the priority pointer.
  - On grant: register the granted addr/wdata/wren into mem_address/mem_data/a pending-wren flag; set owner; set the pointer to the other core; go to ACCESS.
- ACCESS (1 cycle): mem_wren = the granted wren. The memory samples at the end of this cycle. Go to WAIT with counter = mem_latency.
- WAIT (mem_latency cycles): mem_wren=0. On the last WAIT cycle, capture mem_q into the owner's rdata register, reads only. Writes leave rdata unchanged. Go to RESP.
- RESP (1 cycle): the owner's ack is high. Go to IDLE.
- Latency: a req sampled in IDLE at cycle T gives ack at cycle T+2+mem_latency. That is T+3 for the default.
- Timing is identical for reads and writes.
- mem_wren is high for exactly one cycle per write and never for reads.
- mem_address and mem_data hold their last values outside ACCESS.
- A requester drops req (or presents a new request) on the edge ending its ack cycle. IDLE re-samples one cycle later, so no duplicate grant occurs.
- Minimum spacing between grants is 3+mem_latency cycles.
- Once captured, a transaction always completes and acks, even if req falls mid-transaction. Inputs are not re-sampled after capture.
- Requests arriving while busy wait (level-held) until the next IDLE.
- Under continuous requests from both cores, grants strictly alternate. No starvation: worst-case wait is one foreign transaction.
- ack1 and ack2 are never high together.
- Reset mid-transaction: the next cycle is in reset state; mem_wren is forced 0; the in-flight transaction is dropped without ack. A held req is regranted after reset deasserts.
- Address/data pass through unmodified, with no width conversion.

Test Plan:
- Single read: memory preloaded with 12'h0A5 at addr 12'h003; req1=1, wren1=0, addr1=3 sampled at T -> mem_address=3 at T+1, ack1 pulse at T+3, rdata1=12'h0A5, ack2 never high.
- Write then read back: core2 writes 12'h5A3 to addr 12'h010 -> mem_wren high exactly at T+1, ack2 at T+3. Then core1 reads addr 12'h010 -> rdata1=12'h5A3, and rdata2 is unchanged.
- Simultaneous: req1, req2 rise together after reset -> core1 granted first (ack1), then core2 (ack2) 4 cycles later. owner sequence is 0, 1.
- Fairness: both reqs held high for 4 transactions, each re-asserted immediately after ack -> ack order 1, 2, 1, 2; each ack separated by 4 cycles.
- Reset mid-access: assert reset during WAIT of a core1 write -> no ack1, mem_wren=0, all outputs at reset values next cycle. With req1 still held, release reset -> transaction regranted and ack1 at +3 from the IDLE sample.
- mem_latency=2 build: single core2 read sampled at T -> ack2 at T+4 with correct data; mem_q sampled at end of T+3, not T+2.
